// File: rtl/s_term_loopback_ctrl.sv
// South-terminal loopback controller: mirrors the south fabric wires back north (combinational,
// registered, PRBS or parked), with a blanked mode-change handshake and a 16-bit input MISR.
module s_term_loopback_ctrl #(
  parameter int W1         = 4,
  parameter int W2         = 8,
  parameter int W4         = 16,
  parameter int SIG_WINDOW = 256
) (
  input  logic          UserCLK,
  input  logic          RESET,
  input  logic [W1-1:0] S1END,
  input  logic [W2-1:0] S2MID,
  input  logic [W2-1:0] S2END,
  input  logic [W4-1:0] S4END,
  input  logic [W4-1:0] SS4END,
  output logic [W1-1:0] N1BEG,
  output logic [W2-1:0] N2BEG,
  output logic [W2-1:0] N2BEGb,
  output logic [W4-1:0] N4BEG,
  output logic [W4-1:0] NN4BEG,
  input  logic [1:0]    mode_req,
  input  logic          mode_valid,
  output logic          mode_ack,
  output logic [1:0]    mode_cur,
  input  logic          sig_start,
  output logic          sig_busy,
  output logic          sig_valid,
  input  logic          sig_ack,
  output logic [15:0]   signature
);

  localparam int IN_W   = W1 + 2 * W2 + 2 * W4;
  localparam int NSLICE = (IN_W + 15) / 16;
  localparam int PAD_W  = NSLICE * 16;

  localparam logic [1:0] ST_ACTIVE = 2'd0;
  localparam logic [1:0] ST_BLANK  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam logic [1:0] MODE_COMB = 2'd0;
  localparam logic [1:0] MODE_REG  = 2'd1;
  localparam logic [1:0] MODE_PRBS = 2'd2;
  localparam logic [1:0] MODE_PARK = 2'd3;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] SIG_LAST  = 16'(SIG_WINDOW - 1);

  // x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form; shared by PRBS and MISR
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  function automatic logic [15:0] fold16(input logic [PAD_W-1:0] v);
    logic [15:0] acc;
    acc = 16'h0000;
    for (int s = 0; s < NSLICE; s++) begin
      acc = acc ^ v[s*16 +: 16];
    end
    return acc;
  endfunction

  logic [1:0]      state_q, state_d;
  logic [1:0]      mode_lat_q, mode_lat_d;
  logic [1:0]      mode_cur_q, mode_cur_d;
  logic            mode_ack_q, mode_ack_d;
  logic [IN_W-1:0] pipe_q, pipe_d;
  logic [15:0]     lfsr_q, lfsr_d;

  logic            busy_q, busy_d;
  logic            valid_q, valid_d;
  logic [15:0]     misr_q, misr_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [15:0]     sig_q, sig_d;

  logic [W1-1:0]    rev_n1_s;
  logic [W2-1:0]    rev_n2_s;
  logic [W2-1:0]    rev_n2b_s;
  logic [W4-1:0]    rev_n4_s;
  logic [W4-1:0]    rev_nn4_s;
  logic [IN_W-1:0]  rev_all_s;
  logic [IN_W-1:0]  prbs_s;
  logic [IN_W-1:0]  out_bus_s;
  logic [PAD_W-1:0] in_pad_s;
  logic [15:0]      misr_next_s;

  // Bit-reversed loopback of each south bus onto its north partner
  always_comb begin
    rev_n1_s  = {W1{1'b0}};
    rev_n2_s  = {W2{1'b0}};
    rev_n2b_s = {W2{1'b0}};
    rev_n4_s  = {W4{1'b0}};
    rev_nn4_s = {W4{1'b0}};
    for (int i = 0; i < W1; i++) rev_n1_s[i] = S1END[W1-1-i];
    for (int i = 0; i < W2; i++) begin
      rev_n2_s[i]  = S2MID[W2-1-i];
      rev_n2b_s[i] = S2END[W2-1-i];
    end
    for (int i = 0; i < W4; i++) begin
      rev_n4_s[i]  = S4END[W4-1-i];
      rev_nn4_s[i] = SS4END[W4-1-i];
    end
  end

  assign rev_all_s = {rev_nn4_s, rev_n4_s, rev_n2b_s, rev_n2_s, rev_n1_s};
  assign in_pad_s  = PAD_W'({SS4END, S4END, S2END, S2MID, S1END});

  // PRBS pattern repeats the 16-bit LFSR state across the whole north bus
  always_comb begin
    prbs_s = {IN_W{1'b0}};
    for (int k = 0; k < IN_W; k++) prbs_s[k] = lfsr_q[k % 16];
  end

  // North bus mux; forced quiet outside ACTIVE so a mode switch never glitches the fabric
  always_comb begin
    out_bus_s = {IN_W{1'b0}};
    if (state_q == ST_ACTIVE) begin
      case (mode_cur_q)
        MODE_COMB: out_bus_s = rev_all_s;
        MODE_REG:  out_bus_s = pipe_q;
        MODE_PRBS: out_bus_s = prbs_s;
        MODE_PARK: out_bus_s = {IN_W{1'b0}};
        default:   out_bus_s = {IN_W{1'b0}};
      endcase
    end else begin
      out_bus_s = {IN_W{1'b0}};
    end
  end

  assign N1BEG  = out_bus_s[0 +: W1];
  assign N2BEG  = out_bus_s[W1 +: W2];
  assign N2BEGb = out_bus_s[W1 + W2 +: W2];
  assign N4BEG  = out_bus_s[W1 + 2 * W2 +: W4];
  assign NN4BEG = out_bus_s[W1 + 2 * W2 + W4 +: W4];

  // Mode handshake: ACTIVE -> BLANK -> COMMIT -> ACTIVE; requests only accepted in ACTIVE
  always_comb begin
    state_d    = state_q;
    mode_lat_d = mode_lat_q;
    mode_cur_d = mode_cur_q;
    mode_ack_d = 1'b0;
    case (state_q)
      ST_ACTIVE: begin
        if (mode_valid) begin
          state_d    = ST_BLANK;
          mode_lat_d = mode_req;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_BLANK: begin
        state_d    = ST_COMMIT;
        mode_cur_d = mode_lat_q;
        mode_ack_d = 1'b1;
      end
      ST_COMMIT: state_d = ST_ACTIVE;
      default:   state_d = ST_ACTIVE;
    endcase
  end

  // Pipeline stays empty through BLANK/COMMIT so stale data never leaks into the new mode
  always_comb begin
    pipe_d = {IN_W{1'b0}};
    if (state_q == ST_ACTIVE) begin
      pipe_d = rev_all_s;
    end else begin
      pipe_d = {IN_W{1'b0}};
    end
    lfsr_d = lfsr_step(lfsr_q);
    if ((state_q == ST_COMMIT) && (mode_cur_q == MODE_PRBS)) begin
      lfsr_d = LFSR_SEED;
    end else begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  // Mode, loopback pipeline and PRBS state
  always_ff @(posedge UserCLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_ACTIVE;
      mode_lat_q <= MODE_PARK;
      mode_cur_q <= MODE_PARK;
      mode_ack_q <= 1'b0;
      pipe_q     <= {IN_W{1'b0}};
      lfsr_q     <= LFSR_SEED;
    end else begin
      state_q    <= state_d;
      mode_lat_q <= mode_lat_d;
      mode_cur_q <= mode_cur_d;
      mode_ack_q <= mode_ack_d;
      pipe_q     <= pipe_d;
      lfsr_q     <= lfsr_d;
    end
  end

  assign mode_cur = mode_cur_q;
  assign mode_ack = mode_ack_q;

  assign misr_next_s = lfsr_step(misr_q) ^ fold16(in_pad_s);

  // Signature window: idle -> busy for SIG_WINDOW compressions -> valid until acknowledged
  always_comb begin
    busy_d  = busy_q;
    valid_d = valid_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    if (busy_q) begin
      misr_d = misr_next_s;
      if (cnt_q == SIG_LAST) begin
        busy_d  = 1'b0;
        valid_d = 1'b1;
        sig_d   = misr_next_s;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end else if (valid_q) begin
      if (sig_ack) begin
        valid_d = 1'b0;
      end else begin
        valid_d = 1'b1;
      end
    end else if (sig_start) begin
      misr_d = 16'h0000;
      cnt_d  = 16'h0000;
      busy_d = 1'b1;
    end else begin
      busy_d = 1'b0;
    end
  end

  // Signature registers
  always_ff @(posedge UserCLK or posedge RESET) begin
    if (RESET) begin
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      misr_q  <= 16'h0000;
      cnt_q   <= 16'h0000;
      sig_q   <= 16'h0000;
    end else begin
      busy_q  <= busy_d;
      valid_q <= valid_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
    end
  end

  assign sig_busy  = busy_q;
  assign sig_valid = valid_q;
  assign signature = sig_q;

endmodule
